// File: rtl/sum_requester.sv
// sum_requester
//   Hands operand pairs to an external adder responder, waits for the
//   responder's completion edge, checks the returned sum and keeps running
//   pass/fail tallies.
//
//   Optional feature macro: SUM_REQ_TIMEOUT_EN
//     defined   -> a WAIT that sees no done rise ends after TIMEOUT cycles
//                  with a timeout result
//     undefined -> WAIT lasts until a done rise; res_timeout_o stays 0
//
//   Ports
//     clk_i, rst_n_i           clock, async active-low reset
//     in_valid_i/in_ready_o    upstream handshake for an operand pair
//     in_a_i, in_b_i           upstream operands
//     a_o, b_o                 operands presented to the responder
//     sample_o                 one-cycle request strobe to the responder
//     s_i, done_i              responder sum and completion (rising edge)
//     res_valid_o              one-cycle result strobe
//     res_sum_o                captured sum (0 on timeout)
//     res_ok_o, res_timeout_o  result qualifiers, valid with res_valid_o
//     pass_cnt_o, fail_cnt_o   saturating transaction tallies
//     busy_o                   high whenever the FSM is not idle
//
//   state | meaning
//   IDLE  | ready for an operand pair
//   ISSUE | sample strobe to the responder
//   WAIT  | waiting for a fresh done rise (or timeout)
//   GAP   | one dead cycle before returning to IDLE
module sum_requester #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             sample_o,
    input  logic [WIDTH:0]   s_i,
    input  logic             done_i,
    output logic             res_valid_o,
    output logic [WIDTH:0]   res_sum_o,
    output logic             res_ok_o,
    output logic             res_timeout_o,
    output logic [7:0]       pass_cnt_o,
    output logic [7:0]       fail_cnt_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             done_q;
    logic             done_rise;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH:0]   res_sum_q, res_sum_d;
    logic             res_ok_q, res_ok_d;
    logic             res_timeout_q, res_timeout_d;
    logic [7:0]       pass_q, pass_d, fail_q, fail_d;
    logic [WIDTH:0]   sum_exp;
    logic             tmo_hit;

    // A level that was already high before ISSUE never counts: only a
    // fresh 0->1 transition of done is a completion.
    assign done_rise = done_i & ~done_q;
    assign sum_exp   = {1'b0, a_q} + {1'b0, b_q};

`ifdef SUM_REQ_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;

    assign tmo_cnt_inc = tmo_cnt_q + CW'(1);
    // Fires on the WAIT edge at which the count would reach TIMEOUT.
    assign tmo_hit     = (state_q == S_WAIT) && (tmo_cnt_inc == TMO_LIMIT);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_d = tmo_cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        res_valid_d   = 1'b0;
        res_sum_d     = res_sum_q;
        res_ok_d      = res_ok_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A rise on the timeout edge still wins.
                if (done_rise) begin
                    res_valid_d   = 1'b1;
                    res_sum_d     = s_i;
                    res_ok_d      = (s_i == sum_exp);
                    res_timeout_d = 1'b0;
                    state_d       = S_GAP;
                end else if (tmo_hit) begin
                    res_valid_d   = 1'b1;
                    res_sum_d     = '0;
                    res_ok_d      = 1'b0;
                    res_timeout_d = 1'b1;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pass_d = pass_q;
        fail_d = fail_q;
        if (res_valid_d) begin
            if (res_ok_d) begin
                if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
            end else begin
                if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            done_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_sum_q     <= '0;
            res_ok_q      <= 1'b0;
            res_timeout_q <= 1'b0;
            pass_q        <= 8'd0;
            fail_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            done_q        <= done_i;
            res_valid_q   <= res_valid_d;
            res_sum_q     <= res_sum_d;
            res_ok_q      <= res_ok_d;
            res_timeout_q <= res_timeout_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
        end
    end

    assign in_ready_o    = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign sample_o      = (state_q == S_ISSUE);
    assign a_o           = a_q;
    assign b_o           = b_q;
    assign res_valid_o   = res_valid_q;
    assign res_sum_o     = res_sum_q;
    assign res_ok_o      = res_ok_q;
    assign res_timeout_o = res_timeout_q;
    assign pass_cnt_o    = pass_q;
    assign fail_cnt_o    = fail_q;

endmodule

// File: tb/tb_sum_requester.sv
// Directed bench for sum_requester (WIDTH=4, TIMEOUT=16).
// Works with SUM_REQ_TIMEOUT_EN defined or undefined.
module tb_sum_requester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a, in_b, a, b;
    logic       sample;
    logic [4:0] s_bus;
    logic       done;
    logic       res_valid;
    logic [4:0] res_sum;
    logic       res_ok, res_timeout;
    logic [7:0] pass_cnt, fail_cnt;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sample_cnt = 0;
    int rv_cnt = 0;
    int exp_pass = 0;
    int exp_fail = 0;

    sum_requester dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .a_o(a), .b_o(b),
        .sample_o(sample), .s_i(s_bus), .done_i(done),
        .res_valid_o(res_valid), .res_sum_o(res_sum), .res_ok_o(res_ok),
        .res_timeout_o(res_timeout), .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (sample === 1'b1) sample_cnt++;
        if (res_valid === 1'b1) rv_cnt++;
    end

    // One full transaction: accept at edge N, done raised just after edge
    // N+dly, rise seen at edge N+dly+1, result sampled on the following negedge.
    task automatic drive_txn(input logic [3:0] ta, input logic [3:0] tb_v, input logic [4:0] sv,
                             input int dly, output logic got_v, output logic [4:0] got_sum,
                             output logic got_ok, output logic got_tmo, output int n_smp);
        int s0;
        s0 = sample_cnt;
        @(negedge clk); in_valid = 1'b1; in_a = ta; in_b = tb_v;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (dly) @(posedge clk);
        #1 done = 1'b1; s_bus = sv;
        @(posedge clk); @(negedge clk);
        got_v = res_valid; got_sum = res_sum; got_ok = res_ok; got_tmo = res_timeout;
        done = 1'b0; s_bus = 5'd0;
        @(posedge clk); #1;
        n_smp = sample_cnt - s0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (pass_cnt !== 8'd0) begin n_err++; $display("FAIL rst_pass got %0d want 0", pass_cnt); end
        n_vec++; if (fail_cnt !== 8'd0) begin n_err++; $display("FAIL rst_fail got %0d want 0", fail_cnt); end
        n_vec++; if ({a, b, res_sum} !== 13'd0) begin n_err++; $display("FAIL rst_data got %h want 0", {a, b, res_sum}); end
        n_vec++; if ({sample, res_valid, res_ok, res_timeout, busy} !== 5'b0) begin
            n_err++; $display("FAIL rst_flags got %b want 00000", {sample, res_valid, res_ok, res_timeout, busy}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic v, ok, tmo; logic [4:0] sm; int ns;
        drive_txn(4'd3, 4'd5, 5'd8, 3, v, sm, ok, tmo, ns);
        exp_pass++;
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", v); end
        n_vec++; if (sm !== 5'd8) begin n_err++; $display("FAIL basic_sum got %0d want 8", sm); end
        n_vec++; if (ok !== 1'b1 || tmo !== 1'b0) begin n_err++; $display("FAIL basic_ok_tmo got %b%b want 10", ok, tmo); end
        n_vec++; if (ns != 1) begin n_err++; $display("FAIL basic_samples got %0d want 1", ns); end
        n_vec++; if (pass_cnt !== 8'(exp_pass) || fail_cnt !== 8'(exp_fail)) begin
            n_err++; $display("FAIL basic_cnt got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, exp_pass, exp_fail); end
        n_vec++; if (a !== 4'd3 || b !== 4'd5) begin n_err++; $display("FAIL basic_ab got %0d,%0d want 3,5", a, b); end
    endtask

    task automatic test_overflow();
        logic v, ok, tmo; logic [4:0] sm; int ns;
        drive_txn(4'd15, 4'd15, 5'd30, 2, v, sm, ok, tmo, ns);
        exp_pass++;
        n_vec++; if (v !== 1'b1 || sm !== 5'd30 || ok !== 1'b1) begin
            n_err++; $display("FAIL ovf_good got v=%b sum=%0d ok=%b want 1,30,1", v, sm, ok); end
        drive_txn(4'd15, 4'd15, 5'd14, 2, v, sm, ok, tmo, ns);
        exp_fail++;
        n_vec++; if (v !== 1'b1 || sm !== 5'd14 || ok !== 1'b0 || tmo !== 1'b0) begin
            n_err++; $display("FAIL ovf_bad got v=%b sum=%0d ok=%b tmo=%b want 1,14,0,0", v, sm, ok, tmo); end
        n_vec++; if (pass_cnt !== 8'(exp_pass) || fail_cnt !== 8'(exp_fail)) begin
            n_err++; $display("FAIL ovf_cnt got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, exp_pass, exp_fail); end
    endtask

    task automatic test_timeout();
        logic v, ok, tmo; logic [4:0] sm; int ns; int first;
        first = -1;
        @(negedge clk); in_valid = 1'b1; in_a = 4'd7; in_b = 4'd2;
        @(posedge clk); #1 in_valid = 1'b0;
        // j counts negedges after the accept edge N; WAIT starts at edge N+1.
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                first = j; sm = res_sum; ok = res_ok; tmo = res_timeout;
                break;
            end
        end
`ifdef SUM_REQ_TIMEOUT_EN
        exp_fail++;
        n_vec++; if (first != 17) begin n_err++; $display("FAIL tmo_time got %0d want 17", first); end
        n_vec++; if (tmo !== 1'b1 || ok !== 1'b0 || sm !== 5'd0) begin
            n_err++; $display("FAIL tmo_flags got tmo=%b ok=%b sum=%0d want 1,0,0", tmo, ok, sm); end
        @(negedge clk);
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL tmo_strobe got %b want 0", res_valid); end
        @(posedge clk); #1;
`else
        n_vec++; if (first != -1 || busy !== 1'b1) begin
            n_err++; $display("FAIL notmo_wait got first=%0d busy=%b want -1,1", first, busy); end
        done = 1'b1; s_bus = 5'd9;
        @(posedge clk); @(negedge clk);
        exp_pass++;
        n_vec++; if (res_valid !== 1'b1 || res_sum !== 5'd9 || res_ok !== 1'b1 || res_timeout !== 1'b0) begin
            n_err++; $display("FAIL notmo_late got v=%b sum=%0d ok=%b tmo=%b want 1,9,1,0",
                              res_valid, res_sum, res_ok, res_timeout); end
        done = 1'b0; s_bus = 5'd0;
        @(posedge clk); #1;
`endif
        n_vec++; if (pass_cnt !== 8'(exp_pass) || fail_cnt !== 8'(exp_fail)) begin
            n_err++; $display("FAIL tmo_cnt got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, exp_pass, exp_fail); end
        // Rise lands on the very edge the counter reaches TIMEOUT: success.
        drive_txn(4'd3, 4'd4, 5'd7, 16, v, sm, ok, tmo, ns);
        exp_pass++;
        n_vec++; if (v !== 1'b1 || ok !== 1'b1 || tmo !== 1'b0 || sm !== 5'd7) begin
            n_err++; $display("FAIL tmo_edge got v=%b ok=%b tmo=%b sum=%0d want 1,1,0,7", v, ok, tmo, sm); end
    endtask

    task automatic test_ignored_rises();
        int rv0;
        rv0 = rv_cnt; s_bus = 5'd0;
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_a = 4'd6; in_b = 4'd7;
        @(posedge clk); #1 in_valid = 1'b0; done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        @(posedge clk); #1 done = 1'b1; s_bus = 5'd13;
        @(posedge clk); @(negedge clk);
        exp_pass++;
        n_vec++; if (res_valid !== 1'b1 || res_sum !== 5'd13 || res_ok !== 1'b1) begin
            n_err++; $display("FAIL ign_capture got v=%b sum=%0d ok=%b want 1,13,1", res_valid, res_sum, res_ok); end
        done = 1'b0; s_bus = 5'd0;
        @(posedge clk); #1;
        n_vec++; if (rv_cnt - rv0 != 1) begin n_err++; $display("FAIL ign_count got %0d want 1", rv_cnt - rv0); end
        n_vec++; if (pass_cnt !== 8'(exp_pass)) begin n_err++; $display("FAIL ign_pass got %0d want %0d", pass_cnt, exp_pass); end
    endtask

    task automatic test_done_held();
        int rv0;
        rv0 = rv_cnt;
        @(negedge clk); done = 1'b1; s_bus = 5'd0; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b1 || rv_cnt != rv0) begin
            n_err++; $display("FAIL held_wait got busy=%b results=%0d want 1,0", busy, rv_cnt - rv0); end
        done = 1'b0;
        @(posedge clk); #1 done = 1'b1; s_bus = 5'd3;
        @(posedge clk); @(negedge clk);
        exp_pass++;
        n_vec++; if (res_valid !== 1'b1 || res_sum !== 5'd3) begin
            n_err++; $display("FAIL held_fresh got v=%b sum=%0d want 1,3", res_valid, res_sum); end
        done = 1'b0; s_bus = 5'd0;
        @(posedge clk); #1;
        n_vec++; if (rv_cnt - rv0 != 1 || pass_cnt !== 8'(exp_pass)) begin
            n_err++; $display("FAIL held_count got %0d/%0d want 1/%0d", rv_cnt - rv0, pass_cnt, exp_pass); end
    endtask

    task automatic test_reset_mid();
        int rv0;
        rv0 = rv_cnt;
        @(negedge clk); in_valid = 1'b1; in_a = 4'd9; in_b = 4'd6;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
        #1;
        n_vec++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            n_err++; $display("FAIL mid_cnt got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
        n_vec++; if (a !== 4'd0 || b !== 4'd0 || res_sum !== 5'd0) begin
            n_err++; $display("FAIL mid_data got a=%0d b=%0d sum=%0d want 0,0,0", a, b, res_sum); end
        n_vec++; if ({sample, res_valid, res_ok, res_timeout, busy} !== 5'b0) begin
            n_err++; $display("FAIL mid_flags got %b want 00000", {sample, res_valid, res_ok, res_timeout, busy}); end
        exp_pass = 0; exp_fail = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1 || rv_cnt != rv0 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            n_err++; $display("FAIL mid_after got ready=%b results=%0d cnt=%0d/%0d want 1,0,0/0",
                              in_ready, rv_cnt - rv0, pass_cnt, fail_cnt); end
    endtask

    task automatic test_back_to_back();
        int s0, rv0, prev; bit found; logic [3:0] ta, tbv;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_pass = 0; exp_fail = 0;
        s0 = sample_cnt; rv0 = rv_cnt; prev = 0;
        for (int k = 0; k < 10; k++) begin
            ta = 4'(k + 6); tbv = 4'(2 * k + 1);
            in_valid = 1'b1; in_a = ta; in_b = tbv;
            found = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (sample === 1'b1) begin found = 1'b1; break; end
            end
            if (!found) begin
                n_vec++; n_err++; $display("FAIL b2b_sample_%0d got none want pulse within 20 cycles", k);
                break;
            end
            // Responder: done goes high two cycles after the sample cycle
            // ends, so each pair takes accept, issue, 2 wait, rise, gap = 6.
            if (k > 0) begin
                n_vec++; if (cyc - prev != 6) begin
                    n_err++; $display("FAIL b2b_space_%0d got %0d want 6", k, cyc - prev); end
            end
            prev = cyc;
            if (k == 9) in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1 done = 1'b1; s_bus = {1'b0, ta} + {1'b0, tbv};
            @(posedge clk); @(negedge clk);
            done = 1'b0; s_bus = 5'd0;
            exp_pass++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (sample_cnt - s0 != 10 || rv_cnt - rv0 != 10) begin
            n_err++; $display("FAIL b2b_pulses got %0d/%0d want 10/10", sample_cnt - s0, rv_cnt - rv0); end
        n_vec++; if (pass_cnt !== 8'(exp_pass) || fail_cnt !== 8'd0) begin
            n_err++; $display("FAIL b2b_cnt got %0d/%0d want %0d/0", pass_cnt, fail_cnt, exp_pass); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; s_bus = 5'd0; done = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_timeout();
        test_ignored_rises();
        test_done_held();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/sum_requester.md
SUM_REQUESTER -- requirements
Module: sum_requester

Interface
REQ-001 Parameter WIDTH, default 4, operand width; sum width is WIDTH+1.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles to wait for done after sample.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream operand pair valid.
REQ-006 in_ready  out  1  block can accept an operand pair.
REQ-007 in_a, in_b  in  WIDTH each  upstream operands.
REQ-008 a, b  out  WIDTH each  operands driven to the adder responder.
REQ-009 sample  out  1  one-cycle request strobe to the responder.
REQ-010 s  in  WIDTH+1  responder sum bus.
REQ-011 done  in  1  responder completion; its rising edge marks a valid s.
REQ-012 res_valid  out  1  one-cycle result strobe.
REQ-013 res_sum  out  WIDTH+1  captured s.
REQ-014 res_ok  out  1  res_sum equals a+b; valid with res_valid.
REQ-015 res_timeout  out  1  transaction ended by timeout; valid with res_valid.
REQ-016 pass_cnt, fail_cnt  out  8 each  saturating transaction counters.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, GAP.
REQ-019 IDLE: in_ready=1; on in_valid at an edge, latch in_a/in_b into a/b and go to ISSUE.
REQ-020 ISSUE: sample=1 for exactly this one cycle, then go to WAIT.
REQ-021 in_ready=0 in ISSUE, WAIT and GAP; a/b stay stable from ISSUE until IDLE is re-entered.
REQ-022 Rise detection uses a registered done_q; a rise is done=1 with done_q=0 at an edge.
REQ-023 WAIT: on a rise, capture s into res_sum.
REQ-024 WAIT rise, same edge: compute res_ok = (s == zero-extended a + zero-extended b), computed at WIDTH+1 bits with no truncation; set res_timeout=0.
REQ-025 WAIT rise: assert res_valid in the following cycle and go to GAP.
REQ-026 Timeout counter clears on entering WAIT and increments each WAIT cycle.
REQ-027 When the counter reaches TIMEOUT without a rise: res_valid=1, res_timeout=1, res_ok=0, res_sum=0; go to GAP.
REQ-028 A rise on the same edge the counter reaches TIMEOUT counts as success, not timeout.
REQ-029 GAP: one idle cycle, then IDLE; in_valid is ignored in GAP.
REQ-030 Rises of done in IDLE, ISSUE or GAP are ignored and not counted.
REQ-031 done held high from before ISSUE produces no rise; the block waits for a fresh 0->1 transition.
REQ-032 pass_cnt increments when res_valid & res_ok; fail_cnt increments otherwise on res_valid; both saturate at 255.
REQ-033 Latency: in_valid accepted at edge N; sample high in cycle N+1; minimum accept-to-accept spacing is 4 cycles plus the responder delay.

Reset
REQ-034 rst_n low asynchronously forces IDLE and clears done_q and the timeout counter.
REQ-035 rst_n low clears a, b, sample, res_valid, res_sum, res_ok, res_timeout, pass_cnt, fail_cnt and busy to 0; in_ready reads 1 after release.
REQ-036 Reset mid-transaction discards it: no res_valid, and neither counter changes.

Configuration
REQ-037 Macro SUM_REQ_TIMEOUT_EN defined: timeout logic present as in REQ-026 to REQ-028.
REQ-038 SUM_REQ_TIMEOUT_EN undefined: no counter; WAIT lasts until a rise; res_timeout tied 0.

Verification
REQ-039 in_a=3, in_b=5; done rises 3 cycles after sample with s=8 -> one sample pulse, res_valid, res_sum=8, res_ok=1, pass_cnt=1.
REQ-040 in_a=15, in_b=15; s=30 -> res_ok=1; then s=14 for in 15+15 -> res_ok=0, fail_cnt=1.
REQ-041 done never rises, TIMEOUT=16, macro defined -> res_valid exactly 16 cycles after entering WAIT, res_timeout=1, fail_cnt=1.
REQ-042 done pulses during IDLE and ISSUE, then rises in WAIT -> only the WAIT rise is captured; one res_valid.
REQ-043 rst_n pulled low in WAIT -> all outputs 0 immediately; after release, in_ready=1 and counters unchanged at 0.
REQ-044 in_valid held high for 10 pairs, responder delay 2 -> 10 sample pulses, each at least 6 cycles apart, pass_cnt=10.
